// File: rtl/spike_event_fifo_if.sv
// Spike event FIFO bus: capture-side inputs plus pipe-out read side.
// The slave modport is the FIFO; the master modport drives it.
interface spike_event_fifo_if #(
    parameter int NN = 8,
    parameter int AW = 10
);
    logic          capture_en;
    logic [NN:0]   neuron_index;
    logic          spike_in;
    logic          write_phase;
    logic          sim_clk_in;
    logic          rd_en;
    logic [15:0]   dout;
    logic          empty;
    logic          full;
    logic          block_ready;
    logic [AW:0]   count;
    logic          overflow;
    logic [15:0]   drop_cnt;

    modport master (
        output capture_en, neuron_index, spike_in,
        output write_phase, sim_clk_in, rd_en,
        input  dout, empty, full, block_ready,
        input  count, overflow, drop_cnt
    );

    modport slave (
        input  capture_en, neuron_index, spike_in,
        input  write_phase, sim_clk_in, rd_en,
        output dout, empty, full, block_ready,
        output count, overflow, drop_cnt
    );
endinterface

// File: rtl/spike_event_fifo.sv
// Spike/tick event capture into a FWFT FIFO drained by the pipe-out.
// Spike words carry the slot index, tick words carry the tick count.
module spike_event_fifo #(
    parameter int NN        = 8,
    parameter int AW        = 10,
    parameter int BLOCK_LEN = 256
) (
    input  logic clk,
    input  logic reset_global,
    input  logic reset_sim,
    spike_event_fifo_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        WR_TICK,
        WR_SPK
    } arb_state_t;

    localparam int DEPTH = 1 << AW;

    // synchronizers and edge pulses
    logic [2:0]  wp_sync;
    logic [2:0]  sc_sync;
    logic [1:0]  sp_sync;
    logic        wp_pulse;
    logic        sc_pulse;

    // event generation
    logic [14:0] tick_cnt;
    logic        tick_ev;
    logic        spk_ev;

    // arbiter
    arb_state_t  state;
    arb_state_t  state_nxt;
    logic        pend_vld;
    logic        pend_vld_nxt;
    logic [NN:0] pend_idx;
    logic [NN:0] pend_idx_nxt;
    logic        arb_drop;
    logic        wr_req;
    logic [15:0] wr_word;

    // fifo storage and status
    logic [15:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] wr_ptr_nxt;
    logic [AW:0] rd_ptr_nxt;
    logic [AW:0] count_q;
    logic [AW:0] count_nxt;
    logic        empty_q;
    logic        full_q;
    logic        block_ready_q;
    logic        overflow_q;
    logic [15:0] drop_cnt_q;
    logic [15:0] drop_cnt_nxt;
    logic [16:0] drop_sum;
    logic        do_rd;
    logic        do_wr;
    logic        fifo_drop;

    // 2-flop synchronizers with a registered rising-edge pulse
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            wp_sync  <= '0;
            sc_sync  <= '0;
            sp_sync  <= '0;
            wp_pulse <= 1'b0;
            sc_pulse <= 1'b0;
        end else begin
            wp_sync  <= {wp_sync[1:0], bus.write_phase};
            sc_sync  <= {sc_sync[1:0], bus.sim_clk_in};
            sp_sync  <= {sp_sync[0], bus.spike_in};
            wp_pulse <= wp_sync[1] & ~wp_sync[2];
            sc_pulse <= sc_sync[1] & ~sc_sync[2];
        end
    end

    assign tick_ev = sc_pulse & bus.capture_en;
    assign spk_ev  = wp_pulse & sp_sync[1] & bus.capture_en;

    // simulation tick counter, runs even when capture is off
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            tick_cnt <= '0;
        end else if (reset_sim) begin
            tick_cnt <= '0;
        end else if (sc_pulse) begin
            tick_cnt <= tick_cnt + 15'd1;
        end
    end

    // arbiter state and pending spike slot
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            state    <= IDLE;
            pend_vld <= 1'b0;
            pend_idx <= '0;
        end else if (reset_sim) begin
            state    <= IDLE;
            pend_vld <= 1'b0;
            pend_idx <= '0;
        end else begin
            state    <= state_nxt;
            pend_vld <= pend_vld_nxt;
            pend_idx <= pend_idx_nxt;
        end
    end

    // arbiter: tick words win, spike waits one slot in the pending register
    always_comb begin
        state_nxt    = IDLE;
        pend_vld_nxt = pend_vld;
        pend_idx_nxt = pend_idx;
        arb_drop     = 1'b0;
        wr_req       = 1'b0;
        wr_word      = '0;
        unique case (state)
            WR_TICK: begin
                wr_req  = bus.capture_en;
                wr_word = {1'b0, tick_cnt};
            end
            WR_SPK: begin
                wr_req       = bus.capture_en;
                wr_word      = {1'b1, 9'(pend_idx), tick_cnt[5:0]};
                pend_vld_nxt = 1'b0;
            end
            default: begin
            end
        endcase
        if (spk_ev) begin
            if (!pend_vld_nxt) begin
                pend_vld_nxt = 1'b1;
                pend_idx_nxt = bus.neuron_index;
            end else begin
                arb_drop = 1'b1;
            end
        end
        if (tick_ev) begin
            state_nxt = WR_TICK;
        end else if (pend_vld_nxt) begin
            state_nxt = WR_SPK;
        end
    end

    // fifo pointer arithmetic; a read frees room for a same-cycle write
    always_comb begin
        do_rd        = bus.rd_en & ~empty_q;
        do_wr        = wr_req & (~full_q | do_rd);
        fifo_drop    = wr_req & full_q & ~do_rd;
        wr_ptr_nxt   = wr_ptr + (AW+1)'(do_wr);
        rd_ptr_nxt   = rd_ptr + (AW+1)'(do_rd);
        count_nxt    = wr_ptr_nxt - rd_ptr_nxt;
        drop_sum     = {1'b0, drop_cnt_q}
                     + 17'(fifo_drop)
                     + 17'(arb_drop);
        drop_cnt_nxt = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // pointers, registered flags and drop accounting
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count_q       <= '0;
            empty_q       <= 1'b1;
            full_q        <= 1'b0;
            block_ready_q <= 1'b0;
            overflow_q    <= 1'b0;
            drop_cnt_q    <= '0;
        end else if (reset_sim) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count_q       <= '0;
            empty_q       <= 1'b1;
            full_q        <= 1'b0;
            block_ready_q <= 1'b0;
            overflow_q    <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            wr_ptr        <= wr_ptr_nxt;
            rd_ptr        <= rd_ptr_nxt;
            count_q       <= count_nxt;
            empty_q       <= (wr_ptr_nxt == rd_ptr_nxt);
            full_q        <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW])
                          && (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
            block_ready_q <= 32'(count_nxt) >= 32'(BLOCK_LEN);
            overflow_q    <= overflow_q | fifo_drop | arb_drop;
            drop_cnt_q    <= drop_cnt_nxt;
        end
    end

    // word storage; contents need no reset since dout is gated by empty
    always_ff @(posedge clk) begin
        if (do_wr && !reset_sim) begin
            mem[wr_ptr[AW-1:0]] <= wr_word;
        end
    end

    assign bus.dout        = empty_q ? 16'h0000 : mem[rd_ptr[AW-1:0]];
    assign bus.empty       = empty_q;
    assign bus.full        = full_q;
    assign bus.block_ready = block_ready_q;
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;
    assign bus.drop_cnt    = drop_cnt_q;
endmodule
